// File: rtl/phy_pkg.sv
// Shared definitions for the GT PHY transmit path: 8b/10b K/D byte codes,
// the idle word, the header preload and the transmit FSM state encoding.
package phy_pkg;

    // Control and data characters used on the wire
    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] D_ALIGN = 8'h50;
    localparam logic [7:0] K_START = 8'hFB;
    localparam logic [7:0] K_END   = 8'hFD;
    localparam logic [7:0] D_PAD   = 8'h12;

    // Idle filler: comma/align pairs, commas flagged as K characters
    localparam logic [31:0] IDLE_WORD = {D_ALIGN, K_COMMA, D_ALIGN, K_COMMA};
    localparam logic [3:0]  IDLE_K    = 4'b0101;

    // Header shares the idle charisk pattern (comma in byte 0, start in byte 2)
    localparam logic [3:0]  HEADER_K  = 4'b0101;
    localparam logic [3:0]  DATA_K    = 4'b0000;

    // Carry preload so the first beat of a frame produces comma/align/start
    localparam logic [23:0] CARRY_INIT = {K_START, D_ALIGN, K_COMMA};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    // Number of valid bytes in a last beat; an empty keep still carries one byte
    function automatic logic [2:0] keep_to_n(input logic [3:0] keep);
        if (keep[3]) begin
            return 3'd4;
        end else if (keep[2]) begin
            return 3'd3;
        end else if (keep[1]) begin
            return 3'd2;
        end else begin
            return 3'd1;
        end
    endfunction

endpackage

// File: rtl/phy_tx_byte_pack.sv
// Combinational word builder for phy_tx. Normal words place the new beat's
// first byte on top of the three carried bytes; tail words close the frame
// with the end K-char after the remaining carried bytes and pad above it.
module phy_tx_byte_pack
    import phy_pkg::*;
(
    input  logic [23:0] carry,
    input  logic [7:0]  beat_byte,
    input  logic [2:0]  n,
    input  logic        is_header,
    input  logic        is_tail,
    output logic [31:0] word,
    output logic [3:0]  charisk
);

    logic [31:0] carry_ext;

    assign carry_ext = {D_PAD, carry};

    // Select between shifted payload word and end-of-frame tail word
    always_comb begin
        word    = {beat_byte, carry};
        charisk = is_header ? HEADER_K : DATA_K;
        if (is_tail) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(n) - 1) begin
                    word[8*i +: 8] = carry_ext[8*i +: 8];
                end else if (i == int'(n) - 1) begin
                    word[8*i +: 8] = K_END;
                end else begin
                    word[8*i +: 8] = D_PAD;
                end
            end
            charisk = 4'b0001 << (n - 3'd1);
        end
    end

endmodule

// File: rtl/phy_tx.sv
// Transmit framer for the GT PHY link. Takes 32-bit AXI-Stream frames and
// emits header, byte-shifted payload and tail words, with idle fill between.
// Optional feature macro: PHY_TX_FRAME_CNT_EN adds a 16-bit wrapping count
// of transmitted frames on o_frame_cnt.
module phy_tx
    import phy_pkg::*;
#(
    parameter int MIN_GAP = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_axi_s_valid,
    input  logic        i_axi_s_last,
    input  logic [3:0]  i_axi_s_keep,
    input  logic [31:0] i_axi_s_data,
    output logic        o_axi_s_ready,
    input  logic        i_gt_tx_ready,
    output logic [31:0] o_gt_tx_data,
    output logic [3:0]  o_gt_tx_charisk,
    output logic        o_tx_err
`ifdef PHY_TX_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    // Gap counter counts down to zero, so it is loaded with one less than the gap
    localparam logic [3:0] GAP_LOAD = 4'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    tx_state_t   state;
    logic [23:0] carry;
    logic [2:0]  tail_n;
    logic [3:0]  gap_cnt;
    logic        accept;
    logic [31:0] pack_word;
    logic [3:0]  pack_k;

    assign accept = i_axi_s_valid & o_axi_s_ready;

    phy_tx_byte_pack u_byte_pack (
        .carry     (carry),
        .beat_byte (i_axi_s_data[7:0]),
        .n         (tail_n),
        .is_header (state == ST_IDLE),
        .is_tail   (state == ST_TAIL),
        .word      (pack_word),
        .charisk   (pack_k)
    );

    // Framing FSM with carry tracking and registered wire outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state           <= ST_IDLE;
            carry           <= CARRY_INIT;
            tail_n          <= 3'd1;
            gap_cnt         <= 4'd0;
            o_gt_tx_data    <= IDLE_WORD;
            o_gt_tx_charisk <= IDLE_K;
            o_axi_s_ready   <= 1'b0;
            o_tx_err        <= 1'b0;
        end else begin
            o_tx_err        <= 1'b0;
            o_gt_tx_data    <= IDLE_WORD;
            o_gt_tx_charisk <= IDLE_K;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_gt_tx_data    <= pack_word;
                        o_gt_tx_charisk <= pack_k;
                        carry           <= i_axi_s_data[31:8];
                        if (i_axi_s_last) begin
                            tail_n        <= keep_to_n(i_axi_s_keep);
                            state         <= ST_TAIL;
                            o_axi_s_ready <= 1'b0;
                        end else begin
                            state         <= ST_DATA;
                            o_axi_s_ready <= 1'b1;
                        end
                    end else begin
                        o_axi_s_ready <= i_gt_tx_ready;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        o_gt_tx_data    <= pack_word;
                        o_gt_tx_charisk <= pack_k;
                        carry           <= i_axi_s_data[31:8];
                        if (i_axi_s_last) begin
                            tail_n        <= keep_to_n(i_axi_s_keep);
                            state         <= ST_TAIL;
                            o_axi_s_ready <= 1'b0;
                        end else begin
                            o_axi_s_ready <= 1'b1;
                        end
                    end else begin
                        o_tx_err      <= 1'b1;
                        o_axi_s_ready <= 1'b1;
                    end
                end
                ST_TAIL: begin
                    o_gt_tx_data    <= pack_word;
                    o_gt_tx_charisk <= pack_k;
                    carry           <= CARRY_INIT;
                    if (MIN_GAP > 0) begin
                        state         <= ST_GAP;
                        gap_cnt       <= GAP_LOAD;
                        o_axi_s_ready <= 1'b0;
                    end else begin
                        state         <= ST_IDLE;
                        o_axi_s_ready <= i_gt_tx_ready;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state         <= ST_IDLE;
                        o_axi_s_ready <= i_gt_tx_ready;
                    end else begin
                        gap_cnt       <= gap_cnt - 4'd1;
                        o_axi_s_ready <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    o_axi_s_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef PHY_TX_FRAME_CNT_EN
    // Count frames as their tail word goes out on the wire
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_frame_cnt <= 16'd0;
        end else if (state == ST_TAIL) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_tx.sv
// Self-checking bench for phy_tx: a reference model pushes expected wire
// words when beats are accepted, and a negedge monitor pops and compares
// every non-idle word, including the number of idles preceding it.
module tb_phy_tx;

    localparam int          MIN_GAP   = 1;
    localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
    localparam logic [3:0]  IDLE_K    = 4'b0101;
    localparam logic [23:0] HDR_CARRY = 24'hFB50BC;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        int          kind;
        int          gap;
    } expWord_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_axi_s_valid = 1'b0;
    logic        i_axi_s_last = 1'b0;
    logic [3:0]  i_axi_s_keep = 4'b1111;
    logic [31:0] i_axi_s_data = 32'd0;
    logic        o_axi_s_ready;
    logic        i_gt_tx_ready = 1'b1;
    logic [31:0] o_gt_tx_data;
    logic [3:0]  o_gt_tx_charisk;
    logic        o_tx_err;
`ifdef PHY_TX_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    expWord_t    expQ[$];
    int          testsRun = 0;
    int          failCount = 0;
    int          cyc = 0;
    int          idleRun = 0;
    int          lowRun = 0;
    int          lastLowRun = 0;
    int          errCount = 0;
    int          expErr = 0;
    int          hdrCyc = 0;
    int          acceptCyc = 0;
    int          tailsSinceReset = 0;
    logic [31:0] lastHdrData = 32'd0;
    logic [31:0] lastTailData = 32'd0;
    logic [3:0]  lastTailK = 4'd0;
    logic [23:0] tbCarry = HDR_CARRY;
    bit          tbFirst = 1'b1;

    phy_tx #(.MIN_GAP(MIN_GAP)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_axi_s_valid   (i_axi_s_valid),
        .i_axi_s_last    (i_axi_s_last),
        .i_axi_s_keep    (i_axi_s_keep),
        .i_axi_s_data    (i_axi_s_data),
        .o_axi_s_ready   (o_axi_s_ready),
        .i_gt_tx_ready   (i_gt_tx_ready),
        .o_gt_tx_data    (o_gt_tx_data),
        .o_gt_tx_charisk (o_gt_tx_charisk),
        .o_tx_err        (o_tx_err)
`ifdef PHY_TX_FRAME_CNT_EN
        ,
        .o_frame_cnt     (o_frame_cnt)
`endif
    );

    // 100 MHz user clock
    always #5 i_clk = ~i_clk;

    // Free-running cycle index used for latency checks
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: compare non-idle words against the scoreboard
    always @(negedge i_clk) begin
        expWord_t e;
        if (o_tx_err === 1'b1) errCount++;
        if (o_axi_s_ready !== 1'b1) begin
            lowRun++;
        end else begin
            if (lowRun > 0) lastLowRun = lowRun;
            lowRun = 0;
        end
        if (o_gt_tx_data === IDLE_WORD && o_gt_tx_charisk === IDLE_K) begin
            idleRun++;
        end else begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected word", o_gt_tx_data, IDLE_WORD);
            end else begin
                e = expQ.pop_front();
                checkOutput("word data", o_gt_tx_data, e.d);
                checkOutput("word charisk", {28'd0, o_gt_tx_charisk}, {28'd0, e.k});
                if (e.gap >= 0) checkOutput("idles before word", idleRun, e.gap);
                if (e.kind == 0) begin
                    hdrCyc      = cyc;
                    lastHdrData = o_gt_tx_data;
                end
                if (e.kind == 2) begin
                    lastTailData = o_gt_tx_data;
                    lastTailK    = o_gt_tx_charisk;
                end
            end
            idleRun = 0;
        end
    end

    // Drive one beat, wait for acceptance and push its expected wire words
    task automatic sendBeat(input logic [31:0] bd, input logic [3:0] bk, input logic bl, input int gap);
        int       waited = 0;
        int       n;
        expWord_t e;
        @(negedge i_clk);
        i_axi_s_valid = 1'b1;
        i_axi_s_data  = bd;
        i_axi_s_keep  = bk;
        i_axi_s_last  = bl;
        while (o_axi_s_ready !== 1'b1 && waited < 100) begin
            @(negedge i_clk);
            waited++;
        end
        if (o_axi_s_ready !== 1'b1) begin
            checkOutput("ready timeout", 32'd0, 32'd1);
            i_axi_s_valid = 1'b0;
            return;
        end
        if (tbFirst) begin
            acceptCyc = cyc;
            e.d = {bd[7:0], HDR_CARRY};
            e.k = 4'b0101;
            e.kind = 0;
        end else begin
            e.d = {bd[7:0], tbCarry};
            e.k = 4'b0000;
            e.kind = 1;
        end
        e.gap = gap;
        expQ.push_back(e);
        tbCarry = bd[31:8];
        tbFirst = 1'b0;
        if (bl) begin
            n = 1;
            for (int i = 0; i < 4; i++) if (bk[i]) n = i + 1;
            for (int i = 0; i < 4; i++) begin
                if (i < n - 1)       e.d[8*i +: 8] = tbCarry[8*i +: 8];
                else if (i == n - 1) e.d[8*i +: 8] = 8'hFD;
                else                 e.d[8*i +: 8] = 8'h12;
            end
            e.k    = 4'(1 << (n - 1));
            e.kind = 2;
            e.gap  = 0;
            expQ.push_back(e);
            tbFirst = 1'b1;
            tbCarry = HDR_CARRY;
            tailsSinceReset++;
        end
        @(posedge i_clk);
    endtask

    // Send a frame; dropAfter >= 0 inserts a one-cycle valid gap after that beat
    task automatic applyStimulus(input int nBeats, input logic [31:0] beatData, input logic [3:0] lastKeep,
                                 input bit randData, input int dropAfter, input int hdrGap);
        logic [31:0] d;
        int          gap;
        for (int b = 0; b < nBeats; b++) begin
            d   = randData ? $urandom : beatData;
            gap = (b == 0) ? hdrGap : ((b == dropAfter + 1) ? 1 : 0);
            sendBeat(d, (b == nBeats - 1) ? lastKeep : 4'b1111, b == nBeats - 1, gap);
            if (b == dropAfter) begin
                @(negedge i_clk);
                i_axi_s_valid = 1'b0;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        @(negedge i_clk);
        i_axi_s_valid = 1'b0;
        i_axi_s_last  = 1'b0;
        repeat (n - 1) @(negedge i_clk);
    endtask

    // Hard stop in case anything stalls
    initial begin
        #300000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] keepTab [5];
        keepTab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

        // Reset state
        repeat (3) @(negedge i_clk);
        checkOutput("reset data", o_gt_tx_data, IDLE_WORD);
        checkOutput("reset charisk", {28'd0, o_gt_tx_charisk}, {28'd0, IDLE_K});
        checkOutput("reset ready", {31'd0, o_axi_s_ready}, 32'd0);
        checkOutput("reset err", {31'd0, o_tx_err}, 32'd0);
        i_rst = 1'b1;
        idleCycles(3);

        // Reference three-beat frame
        applyStimulus(3, 32'h78563412, 4'b1111, 0, -1, -1);
        idleCycles(4);
        checkOutput("plan header", lastHdrData, 32'h12FB50BC);
        checkOutput("plan tail 1111", lastTailData, 32'hFD785634);
        checkOutput("plan tail k 1111", {28'd0, lastTailK}, 32'h8);

        applyStimulus(3, 32'h78563412, 4'b0001, 0, -1, -1);
        idleCycles(4);
        checkOutput("plan tail 0001", lastTailData, 32'h121212FD);
        checkOutput("plan tail k 0001", {28'd0, lastTailK}, 32'h1);
        applyStimulus(3, 32'h78563412, 4'b0011, 0, -1, -1);
        idleCycles(4);
        checkOutput("plan tail 0011", lastTailData, 32'h1212FD34);
        checkOutput("plan tail k 0011", {28'd0, lastTailK}, 32'h2);
        applyStimulus(3, 32'h78563412, 4'b0111, 0, -1, -1);
        idleCycles(4);
        checkOutput("plan tail 0111", lastTailData, 32'h12FD5634);
        checkOutput("plan tail k 0111", {28'd0, lastTailK}, 32'h4);

        // Single-beat frames including the empty-keep boundary
        applyStimulus(1, 32'hA1B2C3D4, 4'b1111, 0, -1, -1);
        idleCycles(3);
        applyStimulus(1, 32'h0BADF00D, 4'b0000, 0, -1, -1);
        idleCycles(3);

        // Back-to-back frames with valid held high
        applyStimulus(2, 32'h44332211, 4'b1111, 0, -1, -1);
        applyStimulus(3, 32'h88776655, 4'b0011, 0, -1, MIN_GAP);
        idleCycles(4);
        checkOutput("b2b ready low run", lastLowRun, 2);

        // Link down gates new frames
        @(negedge i_clk);
        i_gt_tx_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        i_axi_s_valid = 1'b1;
        i_axi_s_last  = 1'b1;
        i_axi_s_keep  = 4'b1111;
        i_axi_s_data  = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            checkOutput("link down ready", {31'd0, o_axi_s_ready}, 32'd0);
            checkOutput("link down idle", o_gt_tx_data, IDLE_WORD);
        end
        i_gt_tx_ready = 1'b1;
        applyStimulus(1, 32'hCAFEF00D, 4'b1111, 0, -1, -1);
        idleCycles(4);
        checkOutput("link up header latency", hdrCyc - acceptCyc, 1);

        // Underrun after beat 1
        applyStimulus(4, 32'h5A5AA5A5, 4'b0111, 0, 0, -1);
        expErr++;
        idleCycles(4);
        checkOutput("underrun err pulses", errCount, expErr);

        // Random frames
        for (int f = 0; f < 5; f++) begin
            applyStimulus($urandom_range(1, 4), 32'd0, keepTab[$urandom_range(0, 4)], 1, -1, -1);
            idleCycles($urandom_range(1, 3));
        end

        // Reset in the middle of a frame
        sendBeat(32'hDEADBEEF, 4'b1111, 1'b0, -1);
        sendBeat(32'h01234567, 4'b1111, 1'b0, 0);
        @(negedge i_clk);
        #1;
        i_axi_s_valid = 1'b0;
        i_rst = 1'b0;
        @(negedge i_clk);
        #1;
        checkOutput("mid reset data", o_gt_tx_data, IDLE_WORD);
        checkOutput("mid reset charisk", {28'd0, o_gt_tx_charisk}, {28'd0, IDLE_K});
        checkOutput("mid reset ready", {31'd0, o_axi_s_ready}, 32'd0);
        checkOutput("mid reset queue", expQ.size(), 0);
        expQ.delete();
        tbFirst = 1'b1;
        tbCarry = HDR_CARRY;
        tailsSinceReset = 0;
        i_rst = 1'b1;
        applyStimulus(3, 32'h78563412, 4'b1111, 0, -1, -1);
        idleCycles(4);
        checkOutput("post reset header", lastHdrData, 32'h12FB50BC);
        checkOutput("post reset tail", lastTailData, 32'hFD785634);

        idleCycles(8);
        checkOutput("scoreboard drained", expQ.size(), 0);
        checkOutput("total err pulses", errCount, expErr);
`ifdef PHY_TX_FRAME_CNT_EN
        checkOutput("frame count", {16'd0, o_frame_cnt}, tailsSinceReset);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/phy_tx.md
# phy_tx

Transmit half of the GT PHY link. Accepts user frames on a 32-bit AXI-Stream slave and drives a 4-byte GT transmitter (data + charisk), framing each packet as comma/start header, byte-shifted payload and an end K-char. Idle words fill every cycle without a frame. Output is byte-exact with what the team's `phy_rx_2` parses.

## Interface
- `MIN_GAP`, 1: minimum idle words emitted between the end word of one frame and the header of the next (0..15).
- `i_clk`  in  1  PHY user clock (GT TXUSRCLK2 domain).
- `i_rst`  in  1  reset, synchronous, active-low.
- `i_axi_s_valid`  in  1  user beat valid.
- `i_axi_s_last`  in  1  last beat of frame.
- `i_axi_s_keep`  in  4  byte enables, LSB-contiguous; must be 4'b1111 except on the last beat.
- `i_axi_s_data`  in  32  payload; byte 0 = [7:0], first on the wire.
- `o_axi_s_ready`  out  1  beat accepted when valid&ready.
- `i_gt_tx_ready`  in  1  link up (GT reset done and partner aligned).
- `o_gt_tx_data`  out  32  GT TX data.
- `o_gt_tx_charisk`  out  4  per-byte K flag.
- `o_tx_err`  out  1  one-cycle pulse on mid-frame underrun.

## Operation
- K/D codes: comma BC(K), align 50(D), start FB(K), end FD(K), pad 12(D). Idle word 32'h50BC50BC, charisk 4'b0101.
- Output word k of a frame = {beat_k[7:0], carry[23:0]}. Carry is beat_(k-1)[31:8], preloaded with {FB,50,BC}. Header charisk 4'b0101; data words 4'b0000.
- Last beat byte count n = index of highest set keep bit + 1, with keep 4'b0000 treated as n=1. Tail word: bytes 0..n-2 = carry, byte n-1 = FD, higher bytes = pad 12. Tail charisk = 1<<(n-1).
- States:
  - IDLE: emits idle; ready = i_gt_tx_ready. An accepted beat goes to DATA, or to TAIL if last.
  - DATA: ready=1; emits one word per accepted beat. An accepted last beat goes to TAIL.
  - TAIL: ready=0; emits the tail word. Goes to GAP if MIN_GAP>0, else IDLE.
  - GAP: ready=0; emits idle for MIN_GAP cycles, then IDLE.
- Underrun (valid=0 in DATA): emit idle word for that cycle, pulse o_tx_err, stay in DATA, keep carry. Sources must hold valid continuously within a frame.
- i_gt_tx_ready falling mid-frame is ignored until the frame completes. It gates new frames only.

## Timing
- All outputs registered. Reset values: data 32'h50BC50BC, charisk 4'b0101, ready 0, err 0.
- Beat accepted at edge t: its word appears on o_gt_tx_* from t+1.
- Last beat accepted at t: tail at t+2. First idle at t+3. Earliest next header at t+3+MIN_GAP.
- Single-beat frame: header at t+1, tail at t+2.
- Reset asserted mid-frame: next cycle all outputs at reset values, state IDLE, carry reloaded, partial frame dropped.
- Throughput: one frame of N beats occupies N+1+MIN_GAP wire cycles.

## Configuration
- `PHY_TX_FRAME_CNT_EN` defined: adds output `o_frame_cnt` [15:0], reset 0. It increments on the cycle the tail word is driven and wraps 16'hFFFF->0.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Package `phy_pkg`: K/D byte constants (BC, 50, FB, FD, pad 12), IDLE_WORD, IDLE_K, state enum.
- Sub-module `phy_tx_byte_pack` (combinational): takes carry, beat and n. Produces the data/tail word and charisk.
- phy_tx holds the FSM, carry, gap counter and output registers.

## Test plan
- Three beats of 32'h78563412, last keep 4'b1111. Required words in order:
  - 32'h12FB50BC / 4'b0101
  - 32'h12785634 / 4'b0000
  - 32'h12785634 / 4'b0000
  - 32'hFD785634 / 4'b1000
  - then idle.
- Same frame with last keep 4'b0001, 0011, 0111. Required tail words:
  - 32'h121212FD / 4'b0001
  - 32'h1212FD34 / 4'b0010
  - 32'h12FD5634 / 4'b0100
- Back-to-back frames with valid held high, MIN_GAP=1. Required: exactly one idle between tail and header; ready low for 2 cycles.
- i_gt_tx_ready=0 with valid high. Required: ready stays 0 and idle words continue. Raising it gives a header one cycle after acceptance.
- Valid dropped for 1 cycle after beat 1. Required: one idle word, one o_tx_err pulse, then payload resumes with unchanged carry.
- i_rst low during DATA. Required: next cycle idle/4'b0101 and ready 0. A following frame starts from a clean header. With PHY_TX_FRAME_CNT_EN, the count increments per tail only.
